// File: rtl/interp_pkg.sv
// Shared constants, FSM state encoding and width helpers for the interpolating table engine.
package interp_pkg;

  localparam int DEF_DATA_WIDTH        = 64;
  localparam int DEF_FRAC_WIDTH        = 16;
  localparam int DEF_RAM_DEPTH         = 50;
  localparam int DEF_CHANNELS          = 4;
  localparam int DEF_RAM_ADDRESS_WIDTH = 13;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_LOAD = 3'd1,
    ST_READ = 3'd2,
    ST_CALC = 3'd3,
    ST_OUT  = 3'd4
  } state_e;

  // A single-channel build still needs a one-bit channel field.
  function automatic int ch_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/interp_table_engine_if.sv
// Load, query and result handshakes of the interpolating table engine.
interface interp_table_engine_if
  import interp_pkg::*;
#(
  parameter int DATA_WIDTH        = DEF_DATA_WIDTH,
  parameter int FRAC_WIDTH        = DEF_FRAC_WIDTH,
  parameter int CHANNELS          = DEF_CHANNELS,
  parameter int RAM_ADDRESS_WIDTH = DEF_RAM_ADDRESS_WIDTH
) ();

  localparam int CH_W = ch_width(CHANNELS);

  logic                         Load_Start;
  logic [CH_W-1:0]              Load_Channel;
  logic                         Load_Valid;
  logic [DATA_WIDTH-1:0]        Load_Data;
  logic                         Load_End;
  logic                         Load_Ready;
  logic                         Query_Valid;
  logic [CH_W-1:0]              Query_Channel;
  logic [RAM_ADDRESS_WIDTH-1:0] Query_Index;
  logic [FRAC_WIDTH-1:0]        Query_Frac;
  logic                         Query_Ready;
  logic                         Result_Valid;
  logic                         Result_Ready;
  logic [DATA_WIDTH-1:0]        Result_Data;
  logic                         Result_Error;

  modport slave (
    input  Load_Start, Load_Channel, Load_Valid, Load_Data, Load_End,
    input  Query_Valid, Query_Channel, Query_Index, Query_Frac,
    input  Result_Ready,
    output Load_Ready, Query_Ready, Result_Valid, Result_Data, Result_Error
  );

  modport master (
    output Load_Start, Load_Channel, Load_Valid, Load_Data, Load_End,
    output Query_Valid, Query_Channel, Query_Index, Query_Frac,
    output Result_Ready,
    input  Load_Ready, Query_Ready, Result_Valid, Result_Data, Result_Error
  );

endinterface

// File: rtl/interp_dual_read_ram.sv
// Sample storage: one synchronous write port and two independent registered read ports.
module interp_dual_read_ram #(
  parameter int ADDR_WIDTH = 13,
  parameter int DATA_WIDTH = 64,
  parameter int DEPTH      = 200
) (
  input  logic                  clk,
  input  logic                  we_i,
  input  logic [ADDR_WIDTH-1:0] waddr_i,
  input  logic [DATA_WIDTH-1:0] wdata_i,
  input  logic [ADDR_WIDTH-1:0] raddr_a_i,
  input  logic [ADDR_WIDTH-1:0] raddr_b_i,
  output logic [DATA_WIDTH-1:0] rdata_a_o,
  output logic [DATA_WIDTH-1:0] rdata_b_o
);

  localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [DATA_WIDTH-1:0] rdata_a_q;
  logic [DATA_WIDTH-1:0] rdata_b_q;
  logic                  wr_ok;
  logic                  ra_ok;
  logic                  rb_ok;

  // Addresses beyond the array write nothing and read back zero.
  assign wr_ok = we_i && (waddr_i < ADDR_WIDTH'(DEPTH));
  assign ra_ok = raddr_a_i < ADDR_WIDTH'(DEPTH);
  assign rb_ok = raddr_b_i < ADDR_WIDTH'(DEPTH);

  always_ff @(posedge clk) begin
    if (wr_ok) begin
      mem_q[waddr_i[IW-1:0]] <= wdata_i;
    end
    rdata_a_q <= ra_ok ? mem_q[raddr_a_i[IW-1:0]] : '0;
    rdata_b_q <= rb_ok ? mem_q[raddr_b_i[IW-1:0]] : '0;
  end

  assign rdata_a_o = rdata_a_q;
  assign rdata_b_o = rdata_b_q;

endmodule

// File: rtl/interp_table_engine.sv
// Multi-channel sample tables with linear interpolation between neighbouring samples.
// A query is accepted in IDLE and its result is presented three cycles later.
module interp_table_engine
  import interp_pkg::*;
#(
  parameter int DATA_WIDTH        = DEF_DATA_WIDTH,
  parameter int FRAC_WIDTH        = DEF_FRAC_WIDTH,
  parameter int RAM_DEPTH         = DEF_RAM_DEPTH,
  parameter int CHANNELS          = DEF_CHANNELS,
  parameter int RAM_ADDRESS_WIDTH = DEF_RAM_ADDRESS_WIDTH
) (
  input logic                  CLK,
  input logic                  RST,
  interp_table_engine_if.slave bus
);

  localparam int CH_W      = ch_width(CHANNELS);
  localparam int CNT_W     = $clog2(RAM_DEPTH + 1);
  localparam int AW        = RAM_ADDRESS_WIDTH;
  localparam int PW        = DATA_WIDTH + FRAC_WIDTH + 2;
  localparam int MEM_DEPTH = CHANNELS * RAM_DEPTH;

  state_e                state_q;
  logic [CNT_W-1:0]      count_q [CHANNELS];
  logic [CH_W-1:0]       load_ch_q;
  logic [CH_W-1:0]       query_ch_q;
  logic [AW-1:0]         query_idx_q;
  logic [FRAC_WIDTH-1:0] query_frac_q;
  logic [FRAC_WIDTH-1:0] frac_eff_q;
  logic                  calc_err_q;
  logic                  result_valid_q;
  logic                  result_error_q;
  logic [DATA_WIDTH-1:0] result_data_q;

  logic             load_ch_ok;
  logic             load_ready;
  logic             load_fire;
  logic [CNT_W-1:0] load_cnt;
  logic [AW-1:0]    load_addr;

  assign load_ch_ok = 32'(bus.Load_Channel) < CHANNELS;
  assign load_cnt   = count_q[load_ch_q];
  assign load_ready = (state_q == ST_LOAD) && (load_cnt < CNT_W'(RAM_DEPTH));
  assign load_fire  = load_ready && bus.Load_Valid;
  assign load_addr  = AW'(load_ch_q) * AW'(RAM_DEPTH) + AW'(load_cnt);

  logic             query_ready;
  logic             query_fire;
  logic             query_ch_ok;
  logic             query_empty;
  logic             query_clamp;
  logic [CNT_W-1:0] query_cnt;
  logic [AW-1:0]    last_idx;
  logic [AW-1:0]    query_base;
  logic [AW-1:0]    raddr_a;
  logic [AW-1:0]    raddr_b;

  assign query_ready = !RST && (state_q == ST_IDLE) && !bus.Load_Start;
  assign query_fire  = query_ready && bus.Query_Valid;
  assign query_ch_ok = 32'(query_ch_q) < CHANNELS;
  assign query_cnt   = query_ch_ok ? count_q[query_ch_q] : '0;
  assign query_empty = (query_cnt == '0);
  assign last_idx    = AW'(query_cnt) - AW'(1);
  // At or past the last sample both reads land on it and the fraction is dropped.
  assign query_clamp = query_idx_q >= last_idx;
  assign query_base  = AW'(query_ch_q) * AW'(RAM_DEPTH);
  assign raddr_a     = query_base + (query_clamp ? last_idx : query_idx_q);
  assign raddr_b     = query_base + (query_clamp ? last_idx : query_idx_q + AW'(1));

  logic [DATA_WIDTH-1:0]   y0;
  logic [DATA_WIDTH-1:0]   y1;
  logic signed [DATA_WIDTH:0] diff;
  logic signed [PW-1:0]    diff_x;
  logic signed [PW-1:0]    frac_x;
  logic signed [PW-1:0]    prod;
  logic [DATA_WIDTH-1:0]   interp;

  interp_dual_read_ram #(
    .ADDR_WIDTH(AW),
    .DATA_WIDTH(DATA_WIDTH),
    .DEPTH     (MEM_DEPTH)
  ) u_ram (
    .clk      (CLK),
    .we_i     (load_fire),
    .waddr_i  (load_addr),
    .wdata_i  (bus.Load_Data),
    .raddr_a_i(raddr_a),
    .raddr_b_i(raddr_b),
    .rdata_a_o(y0),
    .rdata_b_o(y1)
  );

  // Signed difference times non-negative fraction; the arithmetic shift floors.
  assign diff   = $signed({y1[DATA_WIDTH-1], y1}) - $signed({y0[DATA_WIDTH-1], y0});
  assign diff_x = {{(PW-DATA_WIDTH-1){diff[DATA_WIDTH]}}, diff};
  assign frac_x = {{(PW-FRAC_WIDTH){1'b0}}, frac_eff_q};
  assign prod   = diff_x * frac_x;
  assign interp = y0 + DATA_WIDTH'(prod >>> FRAC_WIDTH);

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q        <= ST_IDLE;
      for (int c = 0; c < CHANNELS; c++) begin
        count_q[c] <= '0;
      end
      load_ch_q      <= '0;
      query_ch_q     <= '0;
      query_idx_q    <= '0;
      query_frac_q   <= '0;
      frac_eff_q     <= '0;
      calc_err_q     <= 1'b0;
      result_valid_q <= 1'b0;
      result_error_q <= 1'b0;
      result_data_q  <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (bus.Load_Start) begin
            if (load_ch_ok) begin
              state_q                   <= ST_LOAD;
              load_ch_q                 <= bus.Load_Channel;
              count_q[bus.Load_Channel] <= '0;
            end
          end else if (query_fire) begin
            state_q      <= ST_READ;
            query_ch_q   <= bus.Query_Channel;
            query_idx_q  <= bus.Query_Index;
            query_frac_q <= bus.Query_Frac;
          end
        end
        ST_LOAD: begin
          if (load_fire) begin
            count_q[load_ch_q] <= load_cnt + CNT_W'(1);
          end
          if (bus.Load_End) begin
            state_q <= ST_IDLE;
          end
        end
        ST_READ: begin
          frac_eff_q <= query_clamp ? '0 : query_frac_q;
          calc_err_q <= !query_ch_ok || query_empty;
          state_q    <= ST_CALC;
        end
        ST_CALC: begin
          result_valid_q <= 1'b1;
          result_error_q <= calc_err_q;
          result_data_q  <= calc_err_q ? '0 : interp;
          state_q        <= ST_OUT;
        end
        ST_OUT: begin
          if (bus.Result_Ready) begin
            result_valid_q <= 1'b0;
            state_q        <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign bus.Load_Ready   = load_ready;
  assign bus.Query_Ready  = query_ready;
  assign bus.Result_Valid = result_valid_q;
  assign bus.Result_Data  = result_data_q;
  assign bus.Result_Error = result_error_q;

endmodule

// File: tb/tb_interp_table_engine.sv
// Self-checking bench: fixed vector table, hand-written corner sequences and random queries
// compared against a plain-arithmetic interpolation model.
module tb_interp_table_engine;

  localparam int DW    = 64;
  localparam int FW    = 16;
  localparam int DEPTH = 50;
  localparam int CH    = 4;
  localparam int AW    = 13;
  localparam longint SCALE = 64'sd1 << FW;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  interp_table_engine_if #(
    .DATA_WIDTH(DW), .FRAC_WIDTH(FW), .CHANNELS(CH), .RAM_ADDRESS_WIDTH(AW)
  ) bus_if ();

  interp_table_engine #(
    .DATA_WIDTH(DW), .FRAC_WIDTH(FW), .RAM_DEPTH(DEPTH), .CHANNELS(CH), .RAM_ADDRESS_WIDTH(AW)
  ) dut (
    .CLK(clk),
    .RST(rst),
    .bus(bus_if)
  );

  typedef struct {
    int     ch;
    int     idx;
    int     frac;
    longint exp_data;
    bit     exp_err;
  } vec_t;

  int     checks = 0;
  int     errors = 0;
  longint model_y [CH][DEPTH];
  int     model_cnt [CH];
  longint load_buf [64];
  vec_t   vecs [11];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference: straight-line interpolation with floor division, from the table contents.
  function automatic void model_query(input int ch, input int idx, input int frac,
                                      output longint d, output bit e);
    int     c;
    longint p;
    longint q;
    if (ch >= CH || model_cnt[ch] == 0) begin
      d = 0;
      e = 1'b1;
      return;
    end
    c = model_cnt[ch];
    e = 1'b0;
    if (idx >= c - 1) begin
      d = model_y[ch][c-1];
    end else begin
      p = (model_y[ch][idx+1] - model_y[ch][idx]) * longint'(frac);
      q = p / SCALE;
      if (p < 0 && q * SCALE != p) q = q - 1;
      d = model_y[ch][idx] + q;
    end
  endfunction

  task automatic load_table(input int ch, input int n, input bit end_with_last);
    bus_if.Load_Start   = 1'b1;
    bus_if.Load_Channel = 2'(ch);
    tick();
    bus_if.Load_Start = 1'b0;
    model_cnt[ch] = 0;
    for (int k = 0; k < n; k++) begin
      bus_if.Load_Valid = 1'b1;
      bus_if.Load_Data  = load_buf[k];
      bus_if.Load_End   = end_with_last && (k == n - 1);
      #1;
      chk("load_ready", bus_if.Load_Ready, 64'(k < DEPTH));
      if (k < DEPTH) begin
        model_y[ch][k] = load_buf[k];
        model_cnt[ch]  = k + 1;
      end
      tick();
    end
    bus_if.Load_Valid = 1'b0;
    if (!end_with_last || n == 0) begin
      bus_if.Load_End = 1'b1;
      tick();
    end
    bus_if.Load_End = 1'b0;
    $display("load ch=%0d samples=%0d stored=%0d", ch, n, model_cnt[ch]);
  endtask

  task automatic do_query(input int ch, input int idx, input int frac, input int hold,
                          input longint exp_d, input bit exp_e, input string tag);
    int n;
    bus_if.Query_Valid   = 1'b1;
    bus_if.Query_Channel = 2'(ch);
    bus_if.Query_Index   = 13'(idx);
    bus_if.Query_Frac    = 16'(frac);
    #1;
    chk({tag, "_qready"}, bus_if.Query_Ready, 64'd1);
    tick();
    bus_if.Query_Valid = 1'b0;
    n = 0;
    while (bus_if.Result_Valid !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    chk({tag, "_latency"}, 64'(n), 64'd2);
    $display("query ch=%0d i=%0d f=0x%04h -> data=%0d err=%0b", ch, idx, frac,
             $signed(bus_if.Result_Data), bus_if.Result_Error);
    chk({tag, "_data"}, bus_if.Result_Data, exp_d);
    chk({tag, "_err"}, bus_if.Result_Error, 64'(exp_e));
    for (int h = 0; h < hold; h++) begin
      tick();
      chk({tag, "_hold_valid"}, bus_if.Result_Valid, 64'd1);
      chk({tag, "_hold_data"}, bus_if.Result_Data, exp_d);
      chk({tag, "_hold_err"}, bus_if.Result_Error, 64'(exp_e));
    end
    bus_if.Result_Ready = 1'b1;
    tick();
    bus_if.Result_Ready = 1'b0;
    #1;
    chk({tag, "_valid_drop"}, bus_if.Result_Valid, 64'd0);
    chk({tag, "_qready_again"}, bus_if.Query_Ready, 64'd1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    longint d;
    bit     e;
    int     ch;
    int     idx;
    int     frac;

    bus_if.Load_Start    = 1'b0;
    bus_if.Load_Channel  = '0;
    bus_if.Load_Valid    = 1'b0;
    bus_if.Load_Data     = '0;
    bus_if.Load_End      = 1'b0;
    bus_if.Query_Valid   = 1'b0;
    bus_if.Query_Channel = '0;
    bus_if.Query_Index   = '0;
    bus_if.Query_Frac    = '0;
    bus_if.Result_Ready  = 1'b0;
    rst = 1'b1;
    for (int c = 0; c < CH; c++) model_cnt[c] = 0;

    repeat (3) tick();
    chk("rst_query_ready", bus_if.Query_Ready, 64'd0);
    chk("rst_load_ready", bus_if.Load_Ready, 64'd0);
    chk("rst_result_valid", bus_if.Result_Valid, 64'd0);
    chk("rst_result_error", bus_if.Result_Error, 64'd0);
    chk("rst_result_data", bus_if.Result_Data, 64'd0);
    rst = 1'b0;
    #1;
    chk("idle_query_ready", bus_if.Query_Ready, 64'd1);
    chk("idle_load_ready", bus_if.Load_Ready, 64'd0);

    load_buf[0] = 100; load_buf[1] = 300;
    load_table(0, 2, 1'b0);
    load_buf[0] = 300; load_buf[1] = 100;
    load_table(1, 2, 1'b0);
    load_buf[0] = 10; load_buf[1] = 20; load_buf[2] = 30;
    load_table(2, 3, 1'b1);

    vecs[0]  = '{ch: 0, idx: 0, frac: 'h8000, exp_data: 200, exp_err: 1'b0};
    vecs[1]  = '{ch: 1, idx: 0, frac: 'h4000, exp_data: 250, exp_err: 1'b0};
    vecs[2]  = '{ch: 0, idx: 0, frac: 'h8000, exp_data: 200, exp_err: 1'b0};
    vecs[3]  = '{ch: 2, idx: 5, frac: 'hFFFF, exp_data: 30,  exp_err: 1'b0};
    vecs[4]  = '{ch: 3, idx: 0, frac: 'h0000, exp_data: 0,   exp_err: 1'b1};
    vecs[5]  = '{ch: 2, idx: 1, frac: 'h8000, exp_data: 25,  exp_err: 1'b0};
    vecs[6]  = '{ch: 2, idx: 2, frac: 'h1234, exp_data: 30,  exp_err: 1'b0};
    vecs[7]  = '{ch: 1, idx: 0, frac: 'h0001, exp_data: 299, exp_err: 1'b0};
    vecs[8]  = '{ch: 0, idx: 1, frac: 'h0000, exp_data: 300, exp_err: 1'b0};
    vecs[9]  = '{ch: 2, idx: 0, frac: 'h4000, exp_data: 12,  exp_err: 1'b0};
    vecs[10] = '{ch: 3, idx: 7, frac: 'hFFFF, exp_data: 0,   exp_err: 1'b1};
    for (int v = 0; v < 11; v++) begin
      do_query(vecs[v].ch, vecs[v].idx, vecs[v].frac, 0, vecs[v].exp_data, vecs[v].exp_err, "vec");
    end

    // 51 writes into a 50-deep channel: the last is refused and not stored.
    for (int k = 0; k < 51; k++) load_buf[k] = 1000 + 7 * k;
    load_table(0, 51, 1'b0);
    do_query(0, 49, 'h0000, 0, 1343, 1'b0, "ovf_last");
    do_query(0, 60, 'hFFFF, 0, 1343, 1'b0, "ovf_clamp");
    do_query(0, 48, 'h8000, 0, 1339, 1'b0, "ovf_interp");

    do_query(2, 1, 'h8000, 5, 25, 1'b0, "hold");

    // Load_Start and Query_Valid together: the load must win.
    bus_if.Load_Start    = 1'b1;
    bus_if.Load_Channel  = 2'd3;
    bus_if.Query_Valid   = 1'b1;
    bus_if.Query_Channel = 2'd0;
    bus_if.Query_Index   = 13'd0;
    bus_if.Query_Frac    = 16'h8000;
    #1;
    chk("race_qready", bus_if.Query_Ready, 64'd0);
    tick();
    bus_if.Load_Start = 1'b0;
    #1;
    chk("race_load_qready", bus_if.Query_Ready, 64'd0);
    chk("race_load_ready", bus_if.Load_Ready, 64'd1);
    bus_if.Query_Valid = 1'b0;
    bus_if.Load_Valid  = 1'b1;
    bus_if.Load_Data   = 777;
    bus_if.Load_End    = 1'b1;
    tick();
    bus_if.Load_Valid = 1'b0;
    bus_if.Load_End   = 1'b0;
    model_y[3][0] = 777;
    model_cnt[3]  = 1;
    chk("race_no_result", bus_if.Result_Valid, 64'd0);
    do_query(3, 0, 'h1234, 0, 777, 1'b0, "race_ch3");

    for (int round = 0; round < 2; round++) begin
      for (int c = 0; c < CH; c++) begin
        int n;
        n = $urandom_range(0, 8);
        for (int k = 0; k < n; k++) begin
          load_buf[k] = (longint'($urandom) - 64'sd2147483648) * 512;
        end
        load_table(c, n, 1'($urandom_range(0, 1)));
      end
      for (int q = 0; q < 30; q++) begin
        ch   = $urandom_range(0, CH - 1);
        idx  = $urandom_range(0, model_cnt[ch] + 3);
        frac = $urandom_range(0, 65535);
        model_query(ch, idx, frac, d, e);
        do_query(ch, idx, frac, $urandom_range(0, 2), d, e, "rand");
      end
    end

    // Reset while the engine is in CALC discards the result and empties every table.
    load_buf[0] = 10; load_buf[1] = 20;
    load_table(2, 2, 1'b0);
    bus_if.Query_Valid   = 1'b1;
    bus_if.Query_Channel = 2'd2;
    bus_if.Query_Index   = 13'd0;
    bus_if.Query_Frac    = 16'h8000;
    tick();
    bus_if.Query_Valid = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    chk("rst_calc_valid", bus_if.Result_Valid, 64'd0);
    chk("rst_calc_data", bus_if.Result_Data, 64'd0);
    chk("rst_calc_qready", bus_if.Query_Ready, 64'd0);
    rst = 1'b0;
    for (int c = 0; c < CH; c++) model_cnt[c] = 0;
    for (int k = 0; k < 4; k++) begin
      tick();
      chk("post_rst_valid", bus_if.Result_Valid, 64'd0);
    end
    for (int c = 0; c < CH; c++) begin
      do_query(c, 0, 'h8000, 0, 0, 1'b1, "post_rst");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
